// File: rtl/sar_adc_ctrl_if.sv
// SAR controller bus: host request/enable, comparator input,
// analog drive outputs and conversion result.
interface sar_adc_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic             start;
    logic             comp_in;
    logic             sample_o;
    logic [WIDTH-1:0] dac_code;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;

    modport slave (
        input  ena,
        input  start,
        input  comp_in,
        output sample_o,
        output dac_code,
        output busy,
        output result,
        output result_valid
    );

    modport master (
        output ena,
        output start,
        output comp_in,
        input  sample_o,
        input  dac_code,
        input  busy,
        input  result,
        input  result_valid
    );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller for the analog SAR macro.
// Optional macro SAR_AVG4_EN: average 4 conversions per start.
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    sar_adc_ctrl_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        DECIDE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             comp_meta_q, comp_meta_d;
    logic             comp_s_q, comp_s_d;
    logic [WIDTH-1:0] code_kept;
    logic [IW-1:0]    idx_dn;
    logic             busy, sample, valid;
`ifdef SAR_AVG4_EN
    localparam int AW = WIDTH + 2;
    logic [AW-1:0]    acc_q, acc_d;
    logic [1:0]       conv_q, conv_d;
    logic [AW-1:0]    sum;
`endif

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dac_q       <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            comp_meta_q <= 1'b0;
            comp_s_q    <= 1'b0;
`ifdef SAR_AVG4_EN
            acc_q       <= '0;
            conv_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dac_q       <= dac_d;
            result_q    <= result_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            comp_meta_q <= comp_meta_d;
            comp_s_q    <= comp_s_d;
`ifdef SAR_AVG4_EN
            acc_q       <= acc_d;
            conv_q      <= conv_d;
`endif
        end
    end

    // Next-state, trial-code update and output decode
    always_comb begin
        state_d     = state_q;
        dac_d       = dac_q;
        result_d    = result_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        comp_meta_d = bus.comp_in;
        comp_s_d    = comp_meta_q;
        busy        = 1'b0;
        sample      = 1'b0;
        valid       = 1'b0;
        idx_dn      = idx_q - IW'(1);
        code_kept   = dac_q;
        code_kept[idx_q] = comp_s_q;
`ifdef SAR_AVG4_EN
        acc_d       = acc_q;
        conv_d      = conv_q;
        sum         = acc_q + AW'(code_kept) + AW'(2);
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.start && bus.ena) begin
                    state_d = SAMPLE;
`ifdef SAR_AVG4_EN
                    acc_d   = '0;
                    conv_d  = '0;
`endif
                end
            end
            SAMPLE: begin
                busy   = 1'b1;
                sample = 1'b1;
                idx_d  = IW'(WIDTH - 1);
                dac_d  = '0;
                dac_d[WIDTH-1] = 1'b1;
                cnt_d  = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                busy = 1'b1;
                if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = DECIDE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DECIDE: begin
                busy = 1'b1;
                if (idx_q != '0) begin
                    dac_d = code_kept;
                    dac_d[idx_dn] = 1'b1;
                    idx_d   = idx_dn;
                    state_d = SETTLE;
                end else begin
                    dac_d = '0;
`ifdef SAR_AVG4_EN
                    if (conv_q != 2'd3) begin
                        acc_d   = acc_q + AW'(code_kept);
                        conv_d  = conv_q + 2'd1;
                        state_d = SAMPLE;
                    end else begin
                        // round half up: (sum of 4 + 2) / 4
                        result_d = sum[AW-1:2];
                        acc_d    = '0;
                        conv_d   = '0;
                        state_d  = DONE;
                    end
`else
                    result_d = code_kept;
                    state_d  = DONE;
`endif
                end
            end
            DONE: begin
                valid   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                dac_d   = '0;
            end
        endcase

        // Enable low abandons the conversion without touching result
        if (!bus.ena && state_q != IDLE) begin
            state_d  = IDLE;
            dac_d    = '0;
            cnt_d    = '0;
            result_d = result_q;
`ifdef SAR_AVG4_EN
            acc_d    = '0;
            conv_d   = '0;
`endif
        end
    end

    assign bus.sample_o     = sample;
    assign bus.busy         = busy;
    assign bus.result_valid = valid;
    assign bus.dac_code     = dac_q;
    assign bus.result       = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl with an ideal comparator model.
// Define SAR_AVG4_EN to exercise the 4-sample averaging build.
module tb_sar_adc_ctrl;
`ifdef SAR_AVG4_EN
    localparam int BUSY_LEN = 100;
`else
    localparam int BUSY_LEN = 25;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] vin;
    int         total = 0;
    int         bad   = 0;
    int         nvalid = 0;
    logic [7:0] exp_q[$];
    logic [7:0] dac_seq[$];

    sar_adc_ctrl_if #(.WIDTH(8)) bus ();

    sar_adc_ctrl #(
        .WIDTH(8),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.comp_in = (vin >= bus.dac_code);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pop the expected result whenever a strobe appears
    always @(negedge clk) begin
        if (rst_n && bus.result_valid) begin
            nvalid++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got %0h want none",
                         bus.result);
            end else begin
                check("result", bus.result, exp_q.pop_front());
            end
        end
    end

    task automatic convert(input logic [31:0] vins, input logic [7:0] exp_r,
                           input int repulse, input string tag);
        int cnt;
        int k;
        int v0;
        logic [7:0] prev;
        v0 = nvalid;
        dac_seq.delete();
        vin = vins[7:0];
        k = 0;
        prev = 8'h00;
        exp_q.push_back(exp_r);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        while (bus.busy && cnt < 400) begin
            cnt++;
            if (bus.sample_o) begin
                vin = vins[8*k +: 8];
                k = (k + 1) % 4;
            end
            if (bus.dac_code != prev && bus.dac_code != 8'h00)
                dac_seq.push_back(bus.dac_code);
            prev = bus.dac_code;
            bus.start = (cnt == repulse);
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, "_busy_len"}, cnt, BUSY_LEN);
        check({tag, "_valid_after_busy"}, {31'd0, bus.result_valid}, 1);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_valid_count"}, nvalid - v0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [7:0] e;
        int v0;
        rst_n = 1'b0;
        bus.ena = 1'b0;
        bus.start = 1'b0;
        vin = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_sample", {31'd0, bus.sample_o}, 0);
        check("rst_dac", bus.dac_code, 0);
        check("rst_result", bus.result, 0);
        check("rst_valid", {31'd0, bus.result_valid}, 0);
        rst_n = 1'b1;
        bus.ena = 1'b1;
        @(negedge clk);

        convert(32'hA5A5A5A5, 8'hA5, -1, "t1");

        convert(32'h00000000, 8'h00, -1, "t2_zero");
        for (int j = 0; j < 8; j++) begin
            e = 8'h80 >> j;
            check($sformatf("t2_zero_trial%0d", j),
                  (j < dac_seq.size()) ? {24'd0, dac_seq[j]} : 32'hFFFF, e);
        end
        convert(32'hFFFFFFFF, 8'hFF, -1, "t2_ones");
        for (int j = 0; j < 8; j++) begin
            e = 8'hFF << (7 - j);
            check($sformatf("t2_ones_trial%0d", j),
                  (j < dac_seq.size()) ? {24'd0, dac_seq[j]} : 32'hFFFF, e);
        end

        convert(32'h5A5A5A5A, 8'h5A, 10, "t3_repulse");

        v0 = nvalid;
        vin = 8'h33;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        while (bus.busy && cnt < 12) begin
            cnt++;
            if (cnt == 12) bus.ena = 1'b0;
            @(negedge clk);
        end
        check("t4_reached_cycle12", cnt, 12);
        check("t4_busy", {31'd0, bus.busy}, 0);
        check("t4_dac", bus.dac_code, 0);
        check("t4_valid", {31'd0, bus.result_valid}, 0);
        check("t4_result_kept", bus.result, 8'h5A);
        bus.ena = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_no_valid", nvalid - v0, 0);
        check("t4_idle", {31'd0, bus.busy}, 0);

        vin = 8'h77;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_busy", {31'd0, bus.busy}, 0);
        check("t5_sample", {31'd0, bus.sample_o}, 0);
        check("t5_dac", bus.dac_code, 0);
        check("t5_result", bus.result, 0);
        check("t5_valid", {31'd0, bus.result_valid}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        convert(32'h3C3C3C3C, 8'h3C, -1, "t5_after");

`ifdef SAR_AVG4_EN
        convert(32'h12111110, 8'h11, -1, "t6_avg4");
`endif

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
